// File: rtl/servant_mem_arbiter.sv
// Three-master round-robin Wishbone classic arbiter in front of the single servant RAM port.
//   m0 = CPU ibus, m1 = CPU dbus, m2 = firmware loader / debug port.
// Grant is registered and the winner keeps the slave until it is acked, the master drops cyc
// (abort) or the transaction times out. A timeout fakes an ack with zero read data and pulses
// o_err for one cycle.
//
// Ports:
//   wb_clk, wb_rst       clock, synchronous active-high reset
//   i_m_adr/dat/sel/we   packed master request fields, master n at slice n
//   i_m_cyc              per-master cycle request
//   o_m_rdt, o_m_ack     read data (broadcast) and per-master ack
//   o_s_*                slave request fields, i_s_rdt/i_s_ack slave response
//   o_gnt, o_busy        current grant index (valid while o_busy), grant-state flag
//   o_err                one-cycle timeout pulse
module servant_mem_arbiter #(
  parameter int unsigned aw      = 32,
  parameter int unsigned timeout = 255
) (
  input  logic            wb_clk,
  input  logic            wb_rst,
  input  logic [3*aw-1:0] i_m_adr,
  input  logic [95:0]     i_m_dat,
  input  logic [11:0]     i_m_sel,
  input  logic [2:0]      i_m_we,
  input  logic [2:0]      i_m_cyc,
  output logic [31:0]     o_m_rdt,
  output logic [2:0]      o_m_ack,
  output logic [aw-1:0]   o_s_adr,
  output logic [31:0]     o_s_dat,
  output logic [3:0]      o_s_sel,
  output logic            o_s_we,
  output logic            o_s_cyc,
  input  logic [31:0]     i_s_rdt,
  input  logic            i_s_ack,
  output logic [1:0]      o_gnt,
  output logic            o_busy,
  output logic            o_err
);

  // Counter is wide enough to reach timeout-1 without wrapping.
  localparam int unsigned CntW = (($clog2(timeout) + 1) > 8) ? ($clog2(timeout) + 1) : 8;
  localparam bit TmoEn = (timeout != 0);
  localparam logic [CntW-1:0] CntLast = (timeout == 0) ? '0 : CntW'(timeout - 1);

  typedef enum logic [0:0] {StIdle, StGrant} state_e;

  state_e          state_q;
  logic [1:0]      gnt_q;
  logic [1:0]      last_q;
  logic [CntW-1:0] cnt_q;

  // Unpacked views of the per-master request fields.
  logic [aw-1:0] m_adr [3];
  logic [31:0]   m_dat [3];
  logic [3:0]    m_sel [3];

  for (genvar n = 0; n < 3; n++) begin : g_unpack
    assign m_adr[n] = i_m_adr[n*aw +: aw];
    assign m_dat[n] = i_m_dat[n*32 +: 32];
    assign m_sel[n] = i_m_sel[n*4 +: 4];
  end

  // Round-robin pick: search starts at the master after the last one served.
  logic [1:0] cand0, cand1, cand2;
  logic [1:0] pick;

  always_comb begin
    unique case (last_q)
      2'd0: begin cand0 = 2'd1; cand1 = 2'd2; cand2 = 2'd0; end
      2'd1: begin cand0 = 2'd2; cand1 = 2'd0; cand2 = 2'd1; end
      default: begin cand0 = 2'd0; cand1 = 2'd1; cand2 = 2'd2; end
    endcase
    if (i_m_cyc[cand0]) begin
      pick = cand0;
    end else if (i_m_cyc[cand1]) begin
      pick = cand1;
    end else begin
      pick = cand2;
    end
  end

  logic in_grant;
  logic cyc_g;
  logic ack_ok;
  logic tmo_hit;

  // Reset gates the response path so an in-flight ack is never forwarded.
  always_comb begin
    in_grant = (state_q == StGrant) && !wb_rst;
    cyc_g    = i_m_cyc[gnt_q];
    // A master that drops cyc in the ack cycle is an abort: nothing is forwarded.
    ack_ok   = in_grant && cyc_g && i_s_ack;
    tmo_hit  = TmoEn && in_grant && cyc_g && !i_s_ack && (cnt_q == CntLast);
  end

  always_comb begin
    o_m_ack = '0;
    if (ack_ok || tmo_hit) begin
      o_m_ack[gnt_q] = 1'b1;
    end
    o_m_rdt = tmo_hit ? 32'h0 : i_s_rdt;
    o_err   = tmo_hit;
    o_s_cyc = in_grant && cyc_g;
    o_s_adr = m_adr[gnt_q];
    o_s_dat = m_dat[gnt_q];
    o_s_sel = m_sel[gnt_q];
    o_s_we  = i_m_we[gnt_q];
    o_busy  = (state_q == StGrant);
    o_gnt   = gnt_q;
  end

  always_ff @(posedge wb_clk) begin
    if (wb_rst) begin
      state_q <= StIdle;
      gnt_q   <= 2'd0;
      last_q  <= 2'd2;
      cnt_q   <= '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (|i_m_cyc) begin
            gnt_q   <= pick;
            cnt_q   <= '0;
            state_q <= StGrant;
          end
        end
        StGrant: begin
          if (!cyc_g) begin
            // Abort keeps the previous owner so priority does not rotate.
            state_q <= StIdle;
          end else if (i_s_ack || tmo_hit) begin
            last_q  <= gnt_q;
            state_q <= StIdle;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_servant_mem_arbiter.sv
module tb_servant_mem_arbiter;

  localparam int AW  = 32;
  localparam int TMO = 4;

  logic            wb_clk = 1'b0;
  logic            wb_rst;
  logic [3*AW-1:0] i_m_adr;
  logic [95:0]     i_m_dat;
  logic [11:0]     i_m_sel;
  logic [2:0]      m_we;
  logic [2:0]      m_cyc;
  logic [31:0]     o_m_rdt;
  logic [2:0]      o_m_ack;
  logic [AW-1:0]   o_s_adr;
  logic [31:0]     o_s_dat;
  logic [3:0]      o_s_sel;
  logic            o_s_we;
  logic            o_s_cyc;
  logic [31:0]     s_rdt;
  logic            s_ack;
  logic [1:0]      o_gnt;
  logic            o_busy;
  logic            o_err;

  logic [AW-1:0] m_adr [3];
  logic [31:0]   m_dat [3];
  logic [3:0]    m_sel [3];

  assign i_m_adr = {m_adr[2], m_adr[1], m_adr[0]};
  assign i_m_dat = {m_dat[2], m_dat[1], m_dat[0]};
  assign i_m_sel = {m_sel[2], m_sel[1], m_sel[0]};

  always #5 wb_clk = ~wb_clk;

  servant_mem_arbiter #(
    .aw      (AW),
    .timeout (TMO)
  ) dut (
    .wb_clk  (wb_clk),
    .wb_rst  (wb_rst),
    .i_m_adr (i_m_adr),
    .i_m_dat (i_m_dat),
    .i_m_sel (i_m_sel),
    .i_m_we  (m_we),
    .i_m_cyc (m_cyc),
    .o_m_rdt (o_m_rdt),
    .o_m_ack (o_m_ack),
    .o_s_adr (o_s_adr),
    .o_s_dat (o_s_dat),
    .o_s_sel (o_s_sel),
    .o_s_we  (o_s_we),
    .o_s_cyc (o_s_cyc),
    .i_s_rdt (s_rdt),
    .i_s_ack (s_ack),
    .o_gnt   (o_gnt),
    .o_busy  (o_busy),
    .o_err   (o_err)
  );

  int total = 0;
  int bad   = 0;

  // Transaction-level reference: who owns the slave, how long it has waited, who was served last.
  int owner = -1;
  int waitc = 0;
  int last  = 2;
  int tmo_seen = 0;
  logic [2:0] exp_ack = '0;
  int gnt_log [$];

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic new_req(input int n, input logic we);
    m_cyc[n] = 1'b1;
    m_we[n]  = we;
    m_adr[n] = $urandom;
    m_dat[n] = $urandom;
    m_sel[n] = 4'($urandom_range(15, 1));
  endtask

  // One clock cycle: inputs are already applied; check outputs mid-cycle, then advance the model.
  task automatic step();
    logic [2:0] ea;
    logic ecyc;
    logic tmo;
    int k;
    int c;
    @(negedge wb_clk);
    ea = '0;
    if (wb_rst) begin
      check_eq("rst_cyc", 32'(o_s_cyc), 0);
      check_eq("rst_ack", 32'(o_m_ack), 0);
      check_eq("rst_err", 32'(o_err), 0);
      owner = -1;
      waitc = 0;
      last  = 2;
    end else begin
      ecyc = (owner >= 0) && m_cyc[owner];
      tmo  = ecyc && !s_ack && (TMO != 0) && (waitc == TMO - 1);
      if (ecyc && (s_ack || tmo)) ea[owner] = 1'b1;
      check_eq("busy", 32'(o_busy), 32'(owner >= 0));
      if (owner >= 0) check_eq("gnt", 32'(o_gnt), 32'(owner));
      check_eq("s_cyc", 32'(o_s_cyc), 32'(ecyc));
      check_eq("m_ack", 32'(o_m_ack), 32'(ea));
      check_eq("err", 32'(o_err), 32'(tmo));
      check_eq("ack_1hot", 32'($countones(o_m_ack) <= 1), 1);
      if (ecyc) begin
        check_eq("s_adr", o_s_adr, m_adr[owner]);
        check_eq("s_dat", o_s_dat, m_dat[owner]);
        check_eq("s_sel", 32'(o_s_sel), 32'(m_sel[owner]));
        check_eq("s_we", 32'(o_s_we), 32'(m_we[owner]));
      end
      if (ea != 0) begin
        check_eq("m_rdt", o_m_rdt, tmo ? 32'h0 : s_rdt);
        gnt_log.push_back(owner);
      end
      if (tmo) tmo_seen++;
      // Advance the reference.
      if (owner < 0) begin
        for (k = 1; k <= 3; k++) begin
          c = (last + k) % 3;
          if (owner < 0 && m_cyc[c]) owner = c;
        end
        waitc = 0;
      end else if (!m_cyc[owner]) begin
        owner = -1;
      end else if (s_ack || tmo) begin
        last  = owner;
        owner = -1;
      end else begin
        waitc++;
      end
    end
    exp_ack = ea;
    @(posedge wb_clk);
    #1;
  endtask

  task automatic drop_acked();
    for (int n = 0; n < 3; n++) begin
      if (exp_ack[n]) m_cyc[n] = 1'b0;
    end
  endtask

  initial begin
    wb_rst = 1'b1;
    m_cyc  = '0;
    m_we   = '0;
    s_ack  = 1'b0;
    s_rdt  = '0;
    for (int n = 0; n < 3; n++) begin
      m_adr[n] = '0;
      m_dat[n] = '0;
      m_sel[n] = '0;
    end
    step();
    step();

    // Reset release, m0 reads 0x100, slave acks one cycle after cyc rises.
    wb_rst = 1'b0;
    step();
    check_eq("reset_busy", 32'(o_busy), 0);
    check_eq("reset_gnt", 32'(o_gnt), 0);
    m_cyc[0] = 1'b1;
    m_we[0]  = 1'b0;
    m_adr[0] = 32'h100;
    m_sel[0] = 4'hf;
    step();                      // arbitration cycle
    step();                      // granted, waiting
    s_ack = 1'b1;
    s_rdt = 32'hDEADBEEF;
    step();                      // ack cycle
    check_eq("t1_ack_seen", 32'(exp_ack), 32'b001);
    m_cyc[0] = 1'b0;
    s_ack = 1'b0;
    step();
    step();

    // m1 writes while m2 waits; m2 must get the slave only afterwards.
    m_cyc[1] = 1'b1;
    m_we[1]  = 1'b1;
    m_adr[1] = 32'h200;
    m_dat[1] = 32'h12345678;
    m_sel[1] = 4'b0011;
    new_req(2, 1'b0);
    step();
    step();
    s_ack = 1'b1;
    step();
    drop_acked();
    step();
    drop_acked();
    s_ack = 1'b0;
    step();

    // Slave never acks: timeout in the 4th grant cycle.
    m_cyc = '0;
    new_req(2, 1'b0);
    for (int i = 0; i < 6; i++) step();
    m_cyc = '0;
    step();

    // Abort: m0 drops after two grant cycles, then keeps top priority over m1.
    new_req(0, 1'b0);
    new_req(1, 1'b0);
    step();
    step();
    step();
    m_cyc[0] = 1'b0;
    step();
    m_cyc[0] = 1'b1;
    step();
    check_eq("abort_regrant", 32'(o_gnt), 0);
    m_cyc = '0;
    step();
    step();

    // Reset mid-grant with an ack pending.
    new_req(1, 1'b0);
    step();
    s_ack  = 1'b1;
    wb_rst = 1'b1;
    step();
    wb_rst = 1'b0;
    s_ack  = 1'b0;
    m_cyc  = '0;
    step();

    // Fairness: all three request continuously, slave acks immediately.
    wb_rst = 1'b1;
    step();
    wb_rst = 1'b0;
    gnt_log.delete();
    for (int n = 0; n < 3; n++) new_req(n, 1'b0);
    s_ack = 1'b1;
    for (int i = 0; i < 20; i++) begin
      s_rdt = $urandom;
      step();
      for (int n = 0; n < 3; n++) if (exp_ack[n]) new_req(n, 1'b0);
    end
    check_eq("fair_len", 32'(gnt_log.size() >= 6), 1);
    for (int k = 0; k < 6 && k < gnt_log.size(); k++) begin
      check_eq("fair_order", 32'(gnt_log[k]), 32'(k % 3));
    end
    s_ack = 1'b0;
    m_cyc = '0;
    step();
    step();

    // Randomized traffic with aborts, random ack latency and occasional resets.
    for (int i = 0; i < 3000; i++) begin
      for (int n = 0; n < 3; n++) begin
        if (m_cyc[n]) begin
          if (exp_ack[n] || ($urandom % 50 == 0)) m_cyc[n] = 1'b0;
        end else if ($urandom % 3 == 0) begin
          new_req(n, 1'($urandom));
        end
      end
      s_ack  = ($urandom % 5) < 2;
      s_rdt  = $urandom;
      wb_rst = ($urandom % 300 == 0);
      step();
    end
    check_eq("tmo_exercised", 32'(tmo_seen > 0), 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
